// File: rtl/spi_flash_reader.sv
// Read-only SPI NOR flash port on the CPU memory bus (mode 0, single or dual-output reads).
// CS stays low after a word so the next sequential read streams on without a new command.
module spi_flash_reader #(
  parameter int unsigned ADDR_BITS = 24,
  parameter int unsigned CLK_DIV   = 1,
  parameter bit          DUAL      = 1'b0,
  parameter bit          CONT      = 1'b1,
  parameter bit          WAKE      = 1'b1,
  parameter int unsigned WAKE_WAIT = 48
) (
  input  logic        clk,
  input  logic        reset,
  output logic        clk_out,
  output logic        csn_out,
  input  logic        io0_in,
  input  logic        io1_in,
  output logic        io0_en,
  output logic        io1_en,
  output logic        io0_out,
  output logic        io1_out,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out
);

  localparam int unsigned TX_W      = 8 + ADDR_BITS;
  localparam int unsigned WORD_W    = ADDR_BITS - 2;
  localparam int unsigned DATA_SCKS = DUAL ? 16 : 32;
  localparam logic [7:0]  CMD_BYTE  = DUAL ? 8'h3B : 8'h03;

  typedef enum logic [3:0] {
    StWakeCmd, StWakeWait, StIdle, StCmd, StDummy, StData, StDone, StHold, StGap
  } state_e;

  state_e              state_q, state_d;
  logic                sck_q, sck_d;
  logic                csn_q, csn_d;
  logic                io0_en_q, io0_en_d;
  logic [15:0]         div_q, div_d;
  logic [6:0]          bit_q, bit_d;
  logic [TX_W-1:0]     tx_q, tx_d;
  logic [31:0]         rx_q, rx_d;
  logic [WORD_W-1:0]   cur_q, cur_d;
  logic [WORD_W-1:0]   next_q, next_d;
  logic                cont_q, cont_d;
  logic                ready_q, ready_d;
  logic [15:0]         wait_q, wait_d;

  logic              run, tick, rise, fall;
  logic              is_read, is_write;
  logic [WORD_W-1:0] req_word;
  logic              unused_bits;

  assign unused_bits = ^{write_value_in, address_in};

  // The strobe cycle itself must not be taken as a fresh request.
  assign is_read  = sel_in && read_in && !ready_q;
  assign is_write = sel_in && !read_in && (|write_mask_in) && !ready_q;
  assign req_word = address_in[ADDR_BITS-1:2];

  assign run  = (state_q == StWakeCmd && !csn_q) || (state_q inside {StCmd, StDummy, StData});
  assign tick = (div_q == 16'(CLK_DIV - 1));
  assign rise = run && tick && !sck_q;
  assign fall = run && tick && sck_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAKE ? StWakeCmd : StIdle;
      sck_q    <= 1'b0;
      csn_q    <= 1'b1;
      io0_en_q <= 1'b1;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      cur_q    <= '0;
      next_q   <= '0;
      cont_q   <= 1'b0;
      ready_q  <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      sck_q    <= sck_d;
      csn_q    <= csn_d;
      io0_en_q <= io0_en_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      cur_q    <= cur_d;
      next_q   <= next_d;
      cont_q   <= cont_d;
      ready_q  <= ready_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sck_d    = sck_q;
    csn_d    = csn_q;
    io0_en_d = io0_en_q;
    div_d    = div_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    cur_d    = cur_q;
    next_d   = next_q;
    cont_d   = cont_q;
    ready_d  = 1'b0;
    wait_d   = wait_q;

    if (run) begin
      if (tick) begin
        div_d = '0;
        sck_d = ~sck_q;
      end else begin
        div_d = div_q + 16'd1;
      end
    end

    unique case (state_q)
      StWakeCmd: begin
        if (csn_q) begin
          csn_d = 1'b0;
          sck_d = 1'b0;
          div_d = '0;
          bit_d = '0;
          tx_d  = {8'hAB, {ADDR_BITS{1'b0}}};
        end else if (fall) begin
          tx_d  = tx_q << 1;
          bit_d = bit_q + 7'd1;
          if (bit_q == 7'd7) begin
            state_d = StWakeWait;
            csn_d   = 1'b1;
            wait_d  = '0;
          end
        end
      end
      StWakeWait: begin
        wait_d = wait_q + 16'd1;
        if (wait_d >= 16'(WAKE_WAIT)) state_d = StIdle;
      end
      StIdle: begin
        if (is_read) begin
          state_d  = StCmd;
          csn_d    = 1'b0;
          sck_d    = 1'b0;
          div_d    = '0;
          bit_d    = '0;
          io0_en_d = 1'b1;
          tx_d     = {CMD_BYTE, req_word, 2'b00};
          cur_d    = req_word;
        end else if (is_write) begin
          ready_d = 1'b1;
        end
      end
      StCmd: begin
        if (fall) begin
          tx_d  = tx_q << 1;
          bit_d = bit_q + 7'd1;
          if (bit_q == 7'(TX_W - 1)) begin
            bit_d   = '0;
            state_d = DUAL ? StDummy : StData;
          end
        end
      end
      StDummy: begin
        // Hand io0 to the flash once the first dummy clock has gone by.
        if (fall) begin
          io0_en_d = 1'b0;
          bit_d    = bit_q + 7'd1;
          if (bit_q == 7'd7) begin
            bit_d   = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (rise) rx_d = DUAL ? {rx_q[29:0], io1_in, io0_in} : {rx_q[30:0], io1_in};
        if (fall) begin
          bit_d = bit_q + 7'd1;
          if (bit_q == 7'(DATA_SCKS - 1)) begin
            bit_d   = '0;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        ready_d = 1'b1;
        next_d  = cur_q + WORD_W'(1);
        if (CONT) begin
          state_d = StHold;
          cont_d  = 1'b1;
        end else begin
          state_d  = StIdle;
          csn_d    = 1'b1;
          io0_en_d = 1'b1;
        end
      end
      StHold: begin
        if (is_read && cont_q && req_word == next_q) begin
          state_d = StData;
          cur_d   = next_q;
          sck_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end else if (is_write) begin
          ready_d = 1'b1;
        end else if (is_read) begin
          state_d  = StGap;
          csn_d    = 1'b1;
          io0_en_d = 1'b1;
          cont_d   = 1'b0;
          wait_d   = '0;
        end
      end
      StGap: begin
        wait_d = wait_q + 16'd1;
        if (wait_d >= 16'(2 * CLK_DIV)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign clk_out   = sck_q;
  assign csn_out   = csn_q;
  assign io0_en    = io0_en_q;
  assign io0_out   = tx_q[TX_W-1];
  assign io1_en    = 1'b0;
  assign io1_out   = 1'b0;
  assign ready_out = ready_q && sel_in;
  // First byte off the wire lands in the low lane.
  assign read_value_out = sel_in ? {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]} : 32'h0;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a single-mode waking reader and a dual-mode non-continuous
// reader, each attached to a small behavioural SPI flash.
module tb_spi_flash_reader;

  logic        clk;
  logic        reset;
  logic        cur;
  logic        sel, rd;
  logic [31:0] addr, wdata;
  logic [3:0]  mask;

  wire  [1:0]  sck, csn, miso, dio0, io0e, io1e, mosi, io1o, ready;
  wire  [31:0] rdata_a, rdata_b;

  wire d_sck    = cur ? sck[1]  : sck[0];
  wire d_csn    = cur ? csn[1]  : csn[0];
  wire d_io0_en = cur ? io0e[1] : io0e[0];
  wire d_mosi   = cur ? mosi[1] : mosi[0];
  wire d_ready  = cur ? ready[1] : ready[0];
  wire [31:0] d_rdata = cur ? rdata_b : rdata_a;

  int n_checks, n_errors;
  int hi_run, max_hi_run, hi_samples, en_low, rise1, rise2;
  logic prev_sck;
  int lat, ncs;
  logic [31:0] data;

  spi_flash_reader #(
    .ADDR_BITS(24), .CLK_DIV(1), .DUAL(1'b0), .CONT(1'b1), .WAKE(1'b1), .WAKE_WAIT(48)
  ) dut_a (
    .clk(clk), .reset(reset), .clk_out(sck[0]), .csn_out(csn[0]), .io0_in(dio0[0]),
    .io1_in(miso[0]), .io0_en(io0e[0]), .io1_en(io1e[0]), .io0_out(mosi[0]),
    .io1_out(io1o[0]), .address_in(addr), .sel_in(sel & ~cur), .read_in(rd),
    .read_value_out(rdata_a), .write_mask_in(mask), .write_value_in(wdata),
    .ready_out(ready[0])
  );

  spi_flash_reader #(
    .ADDR_BITS(24), .CLK_DIV(3), .DUAL(1'b1), .CONT(1'b0), .WAKE(1'b0), .WAKE_WAIT(48)
  ) dut_b (
    .clk(clk), .reset(reset), .clk_out(sck[1]), .csn_out(csn[1]), .io0_in(dio0[1]),
    .io1_in(miso[1]), .io0_en(io0e[1]), .io1_en(io1e[1]), .io0_out(mosi[1]),
    .io1_out(io1o[1]), .address_in(addr), .sel_in(sel & cur), .read_in(rd),
    .read_value_out(rdata_b), .write_mask_in(mask), .write_value_in(wdata),
    .ready_out(ready[1])
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000104: return 8'h11;
      24'h000105: return 8'h22;
      24'h000106: return 8'h33;
      24'h000107: return 8'h44;
      24'h000108: return 8'h55;
      24'h000109: return 8'h66;
      24'h00010A: return 8'h77;
      24'h00010B: return 8'h88;
      default:    return (a[7:0] ^ 8'h5A) + a[15:8] + a[23:16];
    endcase
  endfunction

  // Bit j of the MSB-first byte stream starting at base, wrapping like the flash array.
  function automatic logic sbit(input logic [23:0] base, input int j);
    logic [23:0] a;
    logic [7:0]  b;
    a = base + 24'(j / 8);
    b = mem_byte(a);
    return b[7 - (j % 8)];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_flash
    int          rises;
    int          cs_falls;
    int          k;
    logic [31:0] hdr;
    logic [23:0] fa;
    logic [7:0]  first_cmd;
    logic [7:0]  last_cmd;
    int          n_cmds;
    logic        so1 = 1'b0;
    logic        so0 = 1'b0;

    assign miso[g] = so1;
    assign dio0[g] = so0;

    always @(negedge csn[g]) begin
      rises = 0;
      cs_falls++;
    end

    always @(posedge sck[g]) begin
      if (!csn[g]) begin
        if (rises < 32) hdr = {hdr[30:0], mosi[g]};
        rises++;
        if (rises == 8) begin
          if (n_cmds == 0) first_cmd = hdr[7:0];
          last_cmd = hdr[7:0];
          n_cmds++;
        end
        if (rises == 32) fa = hdr[23:0];
      end
    end

    always @(negedge sck[g]) begin
      if (!csn[g]) begin
        k = rises - ((g == 1) ? 40 : 32);
        if (k >= 0) begin
          if (g == 1) begin
            so1 = sbit(fa, 2 * k);
            so0 = sbit(fa, 2 * k + 1);
          end else begin
            so1 = sbit(fa, k);
          end
        end
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one bus op (read or full-mask write) and wait for the ready strobe.
  task automatic do_op(input logic is_rd, input logic [31:0] a, output int l,
                       output logic [31:0] d);
    logic done;
    sel   = 1'b1;
    rd    = is_rd;
    addr  = a;
    mask  = is_rd ? 4'h0 : 4'hF;
    wdata = 32'hDEADBEEF;
    l = -1; d = '0; done = 1'b0;
    hi_run = 0; max_hi_run = 0; hi_samples = 0; en_low = 0; rise1 = -1; rise2 = -1;
    prev_sck = d_sck;
    for (int n = 1; n <= 3000 && !done; n++) begin
      @(negedge clk);
      if (d_csn) begin
        hi_run++;
        hi_samples++;
        if (hi_run > max_hi_run) max_hi_run = hi_run;
      end else begin
        hi_run = 0;
      end
      if (!d_io0_en) en_low = 1;
      if (d_sck && !prev_sck) begin
        if (rise1 < 0) rise1 = n;
        else if (rise2 < 0) rise2 = n;
      end
      prev_sck = d_sck;
      if (d_ready) begin
        l = n;
        d = d_rdata;
        done = 1'b1;
      end
    end
    sel  = 1'b0;
    rd   = 1'b0;
    mask = 4'h0;
    check_eq("ready_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    cur = 1'b0;
    sel = 1'b0; rd = 1'b0; addr = '0; mask = '0; wdata = '0;
    @(negedge clk);
    // Request held through reset must wait for the wake sequence.
    sel = 1'b1; rd = 1'b1; addr = 32'h104;
    repeat (3) @(negedge clk);
    check_eq("rst_csn", {31'd0, d_csn}, 32'd1);
    check_eq("rst_sck", {31'd0, d_sck}, 32'd0);
    check_eq("rst_ready", {31'd0, d_ready}, 32'd0);
    check_eq("rst_io0_en", {31'd0, d_io0_en}, 32'd1);
    check_eq("rst_io0_out", {31'd0, d_mosi}, 32'd0);
    check_eq("io1_const", {28'd0, io1e, io1o}, 32'd0);

    reset = 1'b0;
    do_op(1'b1, 32'h104, lat, data);
    check_eq("wake_data", data, 32'h44332211);
    check_eq("wake_lat_min", 32'(lat >= 194), 32'd1);
    check_eq("wake_cmd", {24'd0, g_flash[0].first_cmd}, 32'hAB);
    check_eq("wake_csn_gap", 32'(max_hi_run >= 48), 32'd1);
    check_eq("a_cmd", {24'd0, g_flash[0].last_cmd}, 32'h03);
    check_eq("a_addr", {8'd0, g_flash[0].fa}, 32'h000104);

    @(negedge clk);
    ncs = g_flash[0].cs_falls;
    do_op(1'b1, 32'h108, lat, data);
    check_eq("hit_data", data, 32'h88776655);
    check_eq("hit_lat", lat, 66);
    check_eq("hit_csn_low", hi_samples, 0);
    check_eq("hit_no_cmd", g_flash[0].cs_falls, ncs);

    @(negedge clk);
    do_op(1'b1, 32'h200, lat, data);
    check_eq("miss_data", data, 32'h5B5A5D5C);
    check_eq("miss_gap", 32'(max_hi_run >= 2), 32'd1);
    check_eq("miss_addr", {8'd0, g_flash[0].fa}, 32'h000200);
    check_eq("miss_recmd", g_flash[0].cs_falls, ncs + 1);

    @(negedge clk);
    ncs = g_flash[0].cs_falls;
    do_op(1'b0, 32'h10, lat, data);
    check_eq("hold_wr_lat", lat, 1);
    check_eq("hold_wr_csn", hi_samples, 0);
    @(negedge clk);
    do_op(1'b1, 32'h204, lat, data);
    check_eq("after_wr_data", data, 32'h5F5E6160);
    check_eq("after_wr_lat", lat, 66);
    check_eq("after_wr_cs", g_flash[0].cs_falls, ncs);

    @(negedge clk);
    do_op(1'b1, 32'h00FFFFFC, lat, data);
    check_eq("top_data", data, 32'hA3A2A5A4);
    check_eq("top_addr", {8'd0, g_flash[0].fa}, 32'hFFFFFC);
    @(negedge clk);
    do_op(1'b1, 32'h0, lat, data);
    check_eq("wrap_data", data, 32'h59585B5A);
    check_eq("wrap_lat", lat, 66);

    // Reset in the middle of the data phase.
    @(negedge clk);
    sel = 1'b1; rd = 1'b1; addr = 32'h104;
    repeat (100) @(negedge clk);
    check_eq("mid_busy", {31'd0, d_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_csn", {31'd0, d_csn}, 32'd1);
    check_eq("mid_rst_sck", {31'd0, d_sck}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, d_ready}, 32'd0);
    reset = 1'b0;
    do_op(1'b1, 32'h104, lat, data);
    check_eq("mid_data", data, 32'h44332211);
    check_eq("mid_lat_min", 32'(lat >= 194), 32'd1);
    check_eq("mid_cmd", {24'd0, g_flash[0].last_cmd}, 32'h03);

    // Dual-output reader, CLK_DIV=3, no continuous mode.
    @(negedge clk);
    cur = 1'b1;
    @(negedge clk);
    do_op(1'b1, 32'h0, lat, data);
    check_eq("dual_data", data, 32'h59585B5A);
    check_eq("dual_lat", lat, 338);
    check_eq("dual_cmd", {24'd0, g_flash[1].last_cmd}, 32'h3B);
    check_eq("dual_io0_rel", en_low, 1);
    check_eq("dual_sck_per", rise2 - rise1, 6);
    check_eq("dual_csn_end", {31'd0, d_csn}, 32'd1);
    check_eq("dual_io0_en_end", {31'd0, d_io0_en}, 32'd1);

    @(negedge clk);
    ncs = g_flash[1].cs_falls;
    do_op(1'b0, 32'h10, lat, data);
    check_eq("idle_wr_lat", lat, 1);
    check_eq("idle_wr_csn", hi_samples, lat);
    check_eq("idle_wr_cs", g_flash[1].cs_falls, ncs);
    @(negedge clk);
    do_op(1'b1, 32'h104, lat, data);
    check_eq("dual2_data", data, 32'h44332211);
    check_eq("dual2_lat", lat, 338);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
